// File: rtl/stamp_pkg.sv
// Shared constants and entry layout for the timestamp capture FIFO.
// An entry packs {stamp, delta, first} with stamp in the MSBs.
package stamp_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_DCNT_W = 8;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] stamp;
    logic [DEF_WIDTH-1:0] delta;
    logic                 first;
  } entry_t;

  localparam int DEF_ENTRY_W = $bits(entry_t);

  function automatic int entry_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int first_lsb(input int w);
    return 0 * w;
  endfunction

  function automatic int delta_lsb(input int w);
    return 1 + 0 * w;
  endfunction

  function automatic int stamp_lsb(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/stamp_fifo_mem.sv
// Entry storage: DEPTH x EW register array, one synchronous write port,
// one asynchronous read port, no reset on the storage itself.
module stamp_fifo_mem #(
  parameter int EW    = 65,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [EW-1:0] rdata
);

  logic [EW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stamp_fifo.sv
// Captures the upstream count on each trigger with the delta since the last
// accepted capture, buffers entries in a small FIFO, drains via val/rdy.
module stamp_fifo
  import stamp_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DCNT_W = DEF_DCNT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_count,
  input  logic                       trig,
  output logic [WIDTH-1:0]           out_stamp,
  output logic [WIDTH-1:0]           out_delta,
  output logic                       out_first,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [DCNT_W-1:0]          drop_cnt,
  output logic                       overflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int OCC_W   = PTR_W + 1;
  localparam int ENTRY_W = entry_w(WIDTH);
  localparam int S_LSB   = stamp_lsb(WIDTH);
  localparam int D_LSB   = delta_lsb(WIDTH);
  localparam int F_LSB   = first_lsb(WIDTH);

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [WIDTH-1:0]   prev_stamp;
  logic               first_pending;
  logic               full;
  logic               enq;
  logic               deq;
  logic               drop;
  logic [WIDTH-1:0]   delta;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] head;

  assign out_val = (occupancy != '0);
  assign full    = (occupancy == OCC_W'(DEPTH));
  assign deq     = out_val & out_rdy;
  // A dequeue in the same cycle frees the slot, so a full FIFO can still accept.
  assign enq     = trig & (~full | deq);
  assign drop    = trig & full & ~deq;

  assign delta = first_pending ? '0 : (in_count - prev_stamp);
  assign wdata = {in_count, delta, first_pending};

  stamp_fifo_mem #(
    .EW    (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (enq),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Storage is unreset, so mask the head while empty to keep outputs at zero.
  assign out_stamp = out_val ? head[S_LSB +: WIDTH] : '0;
  assign out_delta = out_val ? head[D_LSB +: WIDTH] : '0;
  assign out_first = out_val ? head[F_LSB]          : 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occupancy     <= '0;
      prev_stamp    <= '0;
      first_pending <= 1'b1;
    end else begin
      if (enq) begin
        wr_ptr        <= wr_ptr + PTR_W'(1);
        prev_stamp    <= in_count;
        first_pending <= 1'b0;
      end
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      if (enq && !deq)      occupancy <= occupancy + OCC_W'(1);
      else if (!enq && deq) occupancy <= occupancy - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + DCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stamp_fifo.sv
// Randomised and directed stimulus against a queue-based reference model;
// a negedge monitor compares DUT outputs with the model every cycle.
module tb_stamp_fifo;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int DC = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  in_count;
  logic          trig;
  logic [W-1:0]  out_stamp;
  logic [W-1:0]  out_delta;
  logic          out_first;
  logic          out_val;
  logic          out_rdy;
  logic [2:0]    occupancy;
  logic [DC-1:0] drop_cnt;
  logic          overflow;

  stamp_fifo #(.WIDTH(W), .DEPTH(D), .DCNT_W(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_count  (in_count),
    .trig      (trig),
    .out_stamp (out_stamp),
    .out_delta (out_delta),
    .out_first (out_first),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .occupancy (occupancy),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] stamp;
    logic [W-1:0] delta;
    logic         first;
  } ent_t;

  ent_t         mq[$];
  logic [W-1:0] m_prev;
  bit           m_fp;
  int           m_drops;
  bit           m_ovf;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare against the model, then advance the model by the
  // transaction the upcoming posedge will perform with the current inputs.
  always @(negedge clk) begin
    if (reset) begin
      mq.delete();
      m_prev  = '0;
      m_fp    = 1'b1;
      m_drops = 0;
      m_ovf   = 1'b0;
    end else begin
      bit   d;
      bit   f;
      ent_t e;
      chk("out_val", W'(out_val), W'(mq.size() != 0));
      chk("occupancy", W'(occupancy), W'(mq.size()));
      chk("drop_cnt", W'(drop_cnt), W'(m_drops));
      chk("overflow", W'(overflow), W'(m_ovf));
      if (mq.size() != 0) begin
        chk("out_stamp", out_stamp, mq[0].stamp);
        chk("out_delta", out_delta, mq[0].delta);
        chk("out_first", W'(out_first), W'(mq[0].first));
      end else begin
        chk("empty_stamp", out_stamp, '0);
      end
      d = (mq.size() != 0) && out_rdy;
      f = (mq.size() == D);
      if (d) void'(mq.pop_front());
      if (trig) begin
        if (!f || d) begin
          e.stamp = in_count;
          e.delta = m_fp ? '0 : in_count - m_prev;
          e.first = m_fp;
          mq.push_back(e);
          m_prev = in_count;
          m_fp   = 1'b0;
        end else begin
          if (m_drops < 255) m_drops++;
          m_ovf = 1'b1;
        end
      end
    end
  end

  task automatic drive(input bit t, input logic [W-1:0] c, input bit r);
    trig     = t;
    in_count = c;
    out_rdy  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    trig    = 1'b0;
    out_rdy = 1'b0;
    reset   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [W-1:0] cnt;

  initial begin
    reset    = 1'b1;
    trig     = 1'b0;
    out_rdy  = 1'b0;
    in_count = '0;
    #2;
    chk("reset_val", W'(out_val), '0);
    chk("reset_occ", W'(occupancy), '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // single capture and drain
    drive(1, 32'd10, 0);
    chk("t1_val", W'(out_val), 32'd1);
    chk("t1_stamp", out_stamp, 32'd10);
    chk("t1_first", W'(out_first), 32'd1);
    drive(0, 32'd11, 1);
    chk("t1_drained", W'(out_val), '0);
    drive(0, 32'd12, 0);

    // ordered drain of three
    apply_reset();
    drive(1, 32'd20, 0);
    drive(1, 32'd25, 0);
    drive(1, 32'd40, 0);
    chk("t2_occ", W'(occupancy), 32'd3);
    repeat (3) drive(0, 32'd0, 1);

    // overflow with drops, then simultaneous enqueue/dequeue while full
    apply_reset();
    for (int i = 0; i < 6; i++) drive(1, 32'(100 + 10 * i), 0);
    chk("t3_occ", W'(occupancy), 32'd4);
    chk("t3_drops", W'(drop_cnt), 32'd2);
    chk("t3_ovf", W'(overflow), 32'd1);
    drive(1, 32'd200, 1);
    chk("t4_occ", W'(occupancy), 32'd4);
    chk("t4_drops", W'(drop_cnt), 32'd2);
    repeat (5) drive(0, 32'd0, 1);

    // counter wrap
    apply_reset();
    drive(1, 32'hFFFF_FFFE, 0);
    drive(1, 32'h0000_0003, 0);
    drive(0, 32'd0, 1);
    chk("t5_delta", out_delta, 32'd5);
    drive(0, 32'd0, 1);

    // drop counter saturation
    for (int i = 0; i < 300; i++) drive(1, 32'(i), 0);
    chk("sat_drops", W'(drop_cnt), 32'd255);
    repeat (4) drive(0, 32'd0, 1);

    // random traffic
    apply_reset();
    cnt = 32'hFFFF_FF00;
    for (int i = 0; i < 2000; i++) begin
      cnt = cnt + 32'($urandom_range(0, 40));
      drive(bit'($urandom_range(0, 2) != 0), cnt, bit'($urandom_range(0, 1)));
    end
    repeat (6) drive(0, cnt, 1);

    // asynchronous reset mid-drain
    for (int i = 0; i < 7; i++) drive(1, 32'(500 + i), 0);
    drive(0, 32'd0, 1);
    trig    = 1'b0;
    out_rdy = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("t6_val", W'(out_val), '0);
    chk("t6_occ", W'(occupancy), '0);
    chk("t6_drops", W'(drop_cnt), '0);
    chk("t6_ovf", W'(overflow), '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1, 32'd50, 0);
    chk("t6_first", W'(out_first), 32'd1);
    chk("t6_delta", out_delta, 32'd0);
    drive(1, 32'd57, 1);
    drive(0, 32'd0, 1);
    drive(0, 32'd0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
